// File: rtl/encode_6466b_tx.sv
// 64b/66b Cl.49 transmit encoder: packs MAC beats into 66-bit blocks and enforces the TX block-sequence rules.
// Latency 1 cycle from the block-completing beat; i_gb_pause stalls all state and is mirrored to the MAC.
module encode_6466b_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int ERRCNT_WIDTH = 16
) (
    input  logic                    i_txc,
    input  logic                    i_reset,
    input  logic                    i_init_done,
    input  logic [DATA_WIDTH-1:0]   i_txd,
    input  logic [DATA_WIDTH/8-1:0] i_txctl,
    input  logic                    i_gb_pause,
    output logic                    o_tx_pause,
    output logic [65:0]             o_txd,
    output logic                    o_tx_valid,
    output logic [2:0]              o_tx_state,
    output logic [ERRCNT_WIDTH-1:0] o_err_blocks
);

    localparam logic [65:0] EBLOCK = {2'b10, 8'h1E, {8{7'h1E}}};
    localparam logic [65:0] LBLOCK = {2'b10, 8'h4B, 24'h000001, 32'h0};
    localparam logic [63:0] IDLE8  = 64'h0707_0707_0707_0707;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_C    = 3'd1,
        ST_D    = 3'd2,
        ST_T    = 3'd3,
        ST_E    = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        CL_C,
        CL_S,
        CL_D,
        CL_T,
        CL_E
    } blk_class_e;

    // Lane 0 sits in the most significant byte of blk_dat and the MSB of blk_ctl.
    logic [63:0] blk_dat;
    logic [7:0]  blk_ctl;
    logic        blk_rdy;

    generate
        if (DATA_WIDTH == 64) begin : g_w64
            assign blk_dat = i_txd;
            assign blk_ctl = i_txctl;
            assign blk_rdy = 1'b1;
        end else begin : g_w32
            logic [31:0] hold_dat_q;
            logic [3:0]  hold_ctl_q;
            logic        phase_q;

            always_ff @(posedge i_txc) begin
                if (i_reset) begin
                    hold_dat_q <= '0;
                    hold_ctl_q <= '0;
                    phase_q    <= 1'b0;
                end else if (!i_gb_pause) begin
                    if (!i_init_done) begin
                        hold_dat_q <= '0;
                        hold_ctl_q <= '0;
                        phase_q    <= 1'b0;
                    end else if (!phase_q) begin
                        hold_dat_q <= i_txd;
                        hold_ctl_q <= i_txctl;
                        phase_q    <= 1'b1;
                    end else begin
                        phase_q    <= 1'b0;
                    end
                end
            end

            assign blk_dat = {hold_dat_q, i_txd};
            assign blk_ctl = {hold_ctl_q, i_txctl};
            assign blk_rdy = phase_q;
        end
    endgenerate

    function automatic logic [7:0] t_type(input int k);
        case (k)
            0:       t_type = 8'h87;
            1:       t_type = 8'h99;
            2:       t_type = 8'hAA;
            3:       t_type = 8'hB4;
            4:       t_type = 8'hCC;
            5:       t_type = 8'hD2;
            6:       t_type = 8'hE1;
            default: t_type = 8'hFF;
        endcase
    endfunction

    logic [7:0]  ln [8];
    logic        all_ie;
    logic [55:0] ccodes;
    blk_class_e  cls;
    logic [65:0] enc;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            ln[k] = blk_dat[63-8*k -: 8];
        end
    end

    always_comb begin
        cls    = CL_E;
        enc    = EBLOCK;
        all_ie = 1'b1;
        ccodes = '0;
        for (int k = 0; k < 8; k++) begin
            if (ln[k] == 8'hFE) begin
                ccodes[55-7*k -: 7] = 7'h1E;
            end else if (ln[k] != 8'h07) begin
                all_ie = 1'b0;
            end
        end
        if (blk_ctl == 8'h00) begin
            cls = CL_D;
            enc = {2'b01, blk_dat};
        end else if (blk_ctl == 8'hFF && all_ie) begin
            cls = CL_C;
            enc = {2'b10, 8'h1E, ccodes};
        end else if (blk_ctl == 8'h80 && ln[0] == 8'hFB) begin
            cls = CL_S;
            enc = {2'b10, 8'h78, blk_dat[55:0]};
        end else if (blk_ctl == 8'hF8 && blk_dat[63:32] == IDLE8[63:32] && ln[4] == 8'hFB) begin
            cls = CL_S;
            enc = {2'b10, 8'h33, 32'h0, blk_dat[23:0]};
        end else begin
            // Terminate in lane k: data below k, /T/ at k, idles above.
            for (int k = 0; k < 8; k++) begin
                if (blk_ctl == (8'hFF >> k) && ln[k] == 8'hFD &&
                    (blk_dat & (64'hFFFF_FFFF_FFFF_FFFF >> (8*(k+1)))) ==
                    (IDLE8 & (64'hFFFF_FFFF_FFFF_FFFF >> (8*(k+1))))) begin
                    cls = CL_T;
                    enc = {2'b10, t_type(k),
                           blk_dat[63:8] & ~(56'hFF_FFFF_FFFF_FFFF >> (8*k))};
                end
            end
        end
    end

    tx_state_e                state_q;
    tx_state_e                state_d;
    logic                     legal;
    logic [65:0]              txd_q;
    logic                     vld_q;
    logic [ERRCNT_WIDTH-1:0]  err_q;

    always_comb begin
        case (state_q)
            ST_D:    legal = (cls == CL_D) || (cls == CL_T);
            ST_E:    legal = (cls != CL_E);
            default: legal = (cls == CL_C) || (cls == CL_S);
        endcase
        state_d = ST_E;
        if (legal) begin
            case (cls)
                CL_C:    state_d = ST_C;
                CL_T:    state_d = ST_T;
                default: state_d = ST_D;
            endcase
        end
    end

    always_ff @(posedge i_txc) begin
        if (i_reset) begin
            state_q <= ST_INIT;
            txd_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            vld_q <= 1'b0;
            if (!i_gb_pause) begin
                if (!i_init_done) begin
                    state_q <= ST_INIT;
                    txd_q   <= LBLOCK;
                    vld_q   <= 1'b1;
                end else if (blk_rdy) begin
                    state_q <= state_d;
                    txd_q   <= legal ? enc : EBLOCK;
                    vld_q   <= 1'b1;
                    if (!legal && !(&err_q)) begin
                        err_q <= err_q + 1'b1;
                    end
                end
            end
        end
    end

    assign o_tx_pause   = i_gb_pause;
    assign o_txd        = txd_q;
    assign o_tx_valid   = vld_q;
    assign o_tx_state   = state_q;
    assign o_err_blocks = err_q;

endmodule

// File: tb/tb_encode_6466b_tx.sv
// Bench for encode_6466b_tx: a 64-bit and a 32-bit instance driven with directed and random blocks.
module tb_encode_6466b_tx;

    localparam logic [65:0] EBLK = {2'b10, 8'h1E, {8{7'h1E}}};
    localparam logic [65:0] LBLK = {2'b10, 8'h4B, 8'h00, 8'h00, 8'h01, 32'h0};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_init, a_pause, a_tpause, a_vld;
    logic [63:0] a_txd;
    logic [7:0]  a_ctl;
    logic [65:0] a_out;
    logic [2:0]  a_st;
    logic [15:0] a_err;

    logic        b_init, b_pause, b_tpause, b_vld;
    logic [31:0] b_txd;
    logic [3:0]  b_ctl;
    logic [65:0] b_out;
    logic [2:0]  b_st;
    logic [2:0]  b_err;

    encode_6466b_tx #(.DATA_WIDTH(64), .ERRCNT_WIDTH(16)) u_a (
        .i_txc(clk), .i_reset(rst), .i_init_done(a_init), .i_txd(a_txd), .i_txctl(a_ctl),
        .i_gb_pause(a_pause), .o_tx_pause(a_tpause), .o_txd(a_out), .o_tx_valid(a_vld),
        .o_tx_state(a_st), .o_err_blocks(a_err));

    encode_6466b_tx #(.DATA_WIDTH(32), .ERRCNT_WIDTH(3)) u_b (
        .i_txc(clk), .i_reset(rst), .i_init_done(b_init), .i_txd(b_txd), .i_txctl(b_ctl),
        .i_gb_pause(b_pause), .o_tx_pause(b_tpause), .o_txd(b_out), .o_tx_valid(b_vld),
        .o_tx_state(b_st), .o_err_blocks(b_err));

    typedef struct packed {
        logic [65:0] txd;
        logic [2:0]  st;
        logic [15:0] err;
        logic [31:0] cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Reference state: 0 INIT, 1 C, 2 D, 3 T, 4 E.  Classes: 0 C, 1 S, 2 D, 3 T, 4 E.
    int m_st[2];
    int m_err[2];
    int m_max[2];
    int m_ph;
    logic [31:0] m_hd;
    logic [3:0]  m_hc;
    logic [7:0]  cur_ln[8];
    bit          cur_c[8];

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [65:0] model_block(input logic [63:0] bd, input logic [7:0] bc,
                                                output int cls);
        logic [7:0]  ln[8];
        logic [7:0]  ttype[8];
        bit          c[8];
        int          nctl;
        int          k;
        bit          ok;
        logic [63:0] body;
        ttype = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        nctl = 0;
        for (int i = 0; i < 8; i++) begin
            ln[i] = bd[63-8*i -: 8];
            c[i]  = bc[7-i];
            nctl += int'(c[i]);
        end
        cls = 4;
        if (nctl == 0) begin
            cls = 2;
            return {2'b01, bd};
        end
        ok = (nctl == 8);
        for (int i = 0; i < 8; i++) if (ln[i] != 8'h07 && ln[i] != 8'hFE) ok = 1'b0;
        if (ok) begin
            body = 64'h1E;
            for (int i = 0; i < 8; i++) body = (body << 7) | (ln[i] == 8'hFE ? 64'h1E : 64'h0);
            cls = 0;
            return {2'b10, body};
        end
        if (nctl == 1 && c[0] && ln[0] == 8'hFB) begin
            body = 64'h78;
            for (int i = 1; i < 8; i++) body = (body << 8) | {56'h0, ln[i]};
            cls = 1;
            return {2'b10, body};
        end
        if (nctl == 5 && c[0] && c[1] && c[2] && c[3] && c[4] && ln[0] == 8'h07 && ln[1] == 8'h07 &&
            ln[2] == 8'h07 && ln[3] == 8'h07 && ln[4] == 8'hFB) begin
            body = 64'h33 << 32;
            for (int i = 5; i < 8; i++) body = (body << 8) | {56'h0, ln[i]};
            cls = 1;
            return {2'b10, body};
        end
        k = 0;
        while (k < 7 && !c[k]) k++;
        ok = (nctl == 8 - k) && c[k] && ln[k] == 8'hFD;
        for (int j = k + 1; j < 8; j++) if (ln[j] != 8'h07) ok = 1'b0;
        if (ok) begin
            body = {56'h0, ttype[k]};
            for (int i = 0; i < k; i++) body = (body << 8) | {56'h0, ln[i]};
            body = body << (8 * (7 - k));
            cls = 3;
            return {2'b10, body};
        end
        return EBLK;
    endfunction

    task automatic model_beat(input int sel, input logic [63:0] d, input logic [7:0] c, input bit init);
        exp_t        e;
        logic [63:0] bd;
        logic [7:0]  bc;
        logic [65:0] enc;
        int          cls;
        bit          legal;
        bit          emit;
        emit = 1'b0;
        e.txd = '0;
        if (!init) begin
            e.txd = LBLK;
            m_st[sel] = 0;
            if (sel == 1) m_ph = 0;
            emit = 1'b1;
        end else if (sel == 1 && m_ph == 0) begin
            m_hd = d[31:0];
            m_hc = c[3:0];
            m_ph = 1;
        end else begin
            if (sel == 1) begin
                bd = {m_hd, d[31:0]};
                bc = {m_hc, c[3:0]};
                m_ph = 0;
            end else begin
                bd = d;
                bc = c;
            end
            enc = model_block(bd, bc, cls);
            case (m_st[sel])
                2:       legal = (cls == 2 || cls == 3);
                4:       legal = (cls != 4);
                default: legal = (cls == 0 || cls == 1);
            endcase
            if (legal) begin
                e.txd = enc;
                m_st[sel] = (cls == 0) ? 1 : (cls == 3) ? 3 : 2;
            end else begin
                e.txd = EBLK;
                m_st[sel] = 4;
                if (m_err[sel] < m_max[sel]) m_err[sel]++;
            end
            emit = 1'b1;
        end
        if (emit) begin
            e.st  = 3'(m_st[sel]);
            e.err = 16'(m_err[sel]);
            e.cyc = cyc + 32'd1;
            if (sel == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    // half: 0 whole block (64-bit), 1 lanes 0-3, 2 lanes 4-7 (32-bit instance)
    task automatic drive(input int sel, input int half, input bit pause, input bit init);
        logic [63:0] d;
        logic [7:0]  c;
        for (int i = 0; i < 8; i++) begin
            d[63-8*i -: 8] = cur_ln[i];
            c[7-i]         = cur_c[i];
        end
        if (pause) begin
            d = {$urandom, $urandom};
            c = 8'($urandom);
        end
        @(posedge clk);
        #1;
        if (sel == 0) begin
            a_txd = d; a_ctl = c; a_pause = pause; a_init = init; b_pause = 1'b1;
            if (!pause) model_beat(0, a_txd, a_ctl, init);
        end else begin
            b_txd = (half == 2) ? d[31:0] : d[63:32];
            b_ctl = (half == 2) ? c[3:0] : c[7:4];
            b_pause = pause; b_init = init; a_pause = 1'b1;
            if (!pause) model_beat(1, {32'h0, b_txd}, {4'h0, b_ctl}, init);
        end
        #1;
        check($sformatf("tx_pause%0d", sel), 66'(sel == 0 ? a_tpause : b_tpause), 66'(pause));
    endtask

    task automatic send_blk(input int sel, input int npause);
        if (sel == 0) begin
            repeat (npause) drive(0, 0, 1'b1, 1'b1);
            drive(0, 0, 1'b0, 1'b1);
        end else begin
            drive(1, 1, 1'b0, 1'b1);
            repeat (npause) drive(1, 1, 1'b1, 1'b1);
            drive(1, 2, 1'b0, 1'b1);
        end
    endtask

    task automatic mk_idle();
        for (int i = 0; i < 8; i++) begin cur_ln[i] = 8'h07; cur_c[i] = 1'b1; end
    endtask
    task automatic mk_data();
        for (int i = 0; i < 8; i++) begin cur_ln[i] = 8'($urandom); cur_c[i] = 1'b0; end
    endtask
    task automatic mk_s0();
        for (int i = 0; i < 8; i++) begin cur_ln[i] = 8'h55; cur_c[i] = (i == 0); end
        cur_ln[0] = 8'hFB;
        cur_ln[7] = 8'hD5;
    endtask
    task automatic mk_s4();
        for (int i = 0; i < 8; i++) begin
            cur_ln[i] = (i < 4) ? 8'h07 : 8'($urandom);
            cur_c[i]  = (i < 5);
        end
        cur_ln[4] = 8'hFB;
    endtask
    task automatic mk_term(input int k);
        for (int i = 0; i < 8; i++) begin
            cur_ln[i] = (i < k) ? 8'($urandom) : 8'h07;
            cur_c[i]  = (i >= k);
        end
        cur_ln[k] = 8'hFD;
    endtask
    task automatic mk_garbage();
        logic [7:0] pool[6];
        pool = '{8'h07, 8'hFE, 8'hFB, 8'hFD, 8'h9C, 8'h00};
        for (int i = 0; i < 8; i++) begin
            cur_c[i]  = 1'($urandom);
            cur_ln[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : pool[$urandom_range(0, 5)];
        end
    endtask

    task automatic pop_check(input int sel);
        exp_t        e;
        logic [65:0] o;
        logic [2:0]  st;
        logic [15:0] er;
        if (sel == 0) begin o = a_out; st = a_st; er = a_err; end
        else begin o = b_out; st = b_st; er = {13'h0, b_err}; end
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_block%0d: got %h, expected no block", sel, o);
            return;
        end
        if (sel == 0) e = q0.pop_front();
        else e = q1.pop_front();
        check($sformatf("txd%0d", sel), o, e.txd);
        check($sformatf("state%0d", sel), 66'(st), 66'(e.st));
        check($sformatf("errcnt%0d", sel), 66'(er), 66'(e.err));
        check($sformatf("cycle%0d", sel), 66'(cyc), 66'(e.cyc));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_vld) pop_check(0);
            if (b_vld) pop_check(1);
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        a_pause = 1'b1;
        b_pause = 1'b1;
        @(negedge clk);
        #1;
        check("pending0", 66'(q0.size()), 66'd0);
        check("pending1", 66'(q1.size()), 66'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_txd0", a_out, 66'd0);
        check("rst_vld0", 66'(a_vld), 66'd0);
        check("rst_st0", 66'(a_st), 66'd0);
        check("rst_err0", 66'(a_err), 66'd0);
        check("rst_txd1", b_out, 66'd0);
        check("rst_vld1", 66'(b_vld), 66'd0);
        check("rst_st1", 66'(b_st), 66'd0);
        check("rst_err1", 66'(b_err), 66'd0);
        m_st[0] = 0; m_st[1] = 0; m_err[0] = 0; m_err[1] = 0; m_ph = 0;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int sel;
        rst = 1'b1;
        a_init = 1'b1; a_pause = 1'b1; a_txd = '0; a_ctl = '0;
        b_init = 1'b1; b_pause = 1'b1; b_txd = '0; b_ctl = '0;
        m_max[0] = 65535;
        m_max[1] = 7;
        mk_idle();
        do_reset();

        // Idle on the 64-bit path, back to back
        repeat (3) begin mk_idle(); send_blk(0, 0); end

        // 32-bit frame: idle, S0, two data, T3
        mk_idle(); send_blk(1, 0);
        mk_s0(); send_blk(1, 0);
        repeat (2) begin mk_data(); send_blk(1, 0); end
        mk_term(3); send_blk(1, 0);

        // Every terminate position after a data block
        for (int k = 0; k < 8; k++) begin
            mk_s0(); send_blk(0, 0);
            mk_data(); send_blk(0, 0);
            mk_term(k); send_blk(0, 0);
            mk_idle(); send_blk(0, 0);
        end

        // Illegal sequences
        mk_idle(); send_blk(0, 0);
        mk_data(); send_blk(0, 0);
        mk_idle(); cur_ln[3] = 8'h9C; send_blk(0, 0);
        mk_s4(); cur_ln[0] = 8'hFE; send_blk(0, 0);
        mk_idle(); send_blk(0, 0);
        mk_s4(); send_blk(0, 0);
        mk_term(7); send_blk(0, 0);

        // Gearbox pause between halves
        mk_idle(); send_blk(1, 0);
        mk_s0(); send_blk(1, 3);
        mk_data(); send_blk(1, 2);
        mk_term(5); send_blk(1, 1);

        // init_done dropped mid-frame, then restored with a start
        mk_s0(); send_blk(0, 0);
        mk_data(); send_blk(0, 0);
        drive(0, 0, 1'b0, 1'b0);
        mk_s0(); send_blk(0, 0);
        mk_s0(); send_blk(1, 0);
        mk_data(); drive(1, 1, 1'b0, 1'b1); drive(1, 2, 1'b0, 1'b0);
        mk_s0(); send_blk(1, 0);

        // Reset with a half block stored
        mk_data(); drive(1, 1, 1'b0, 1'b1);
        do_reset();
        mk_idle(); send_blk(1, 0);
        mk_idle(); send_blk(0, 0);

        // Error counter saturation on the narrow counter
        repeat (10) begin mk_idle(); cur_ln[0] = 8'h9C; send_blk(1, 0); end
        mk_idle(); send_blk(1, 0);

        // Random frames with random pauses
        for (int it = 0; it < 80; it++) begin
            sel = $urandom_range(0, 1);
            repeat ($urandom_range(1, 2)) begin mk_idle(); send_blk(sel, $urandom_range(0, 1)); end
            if ($urandom_range(0, 1) == 0) mk_s0(); else mk_s4();
            send_blk(sel, $urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) begin mk_data(); send_blk(sel, $urandom_range(0, 1)); end
            mk_term($urandom_range(0, 7)); send_blk(sel, $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin mk_garbage(); send_blk(sel, 0); end
            if ($urandom_range(0, 5) == 0) begin mk_data(); send_blk(sel, 0); end
        end

        @(posedge clk);
        #1;
        a_pause = 1'b1;
        b_pause = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("leftover0", 66'(q0.size()), 66'd0);
        check("leftover1", 66'(q1.size()), 66'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
